// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: PC source encodings, opcode classes,
// IR field positions and the illegal-opcode rule.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RESET  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    OPC_J  = 2'b00,
    OPC_R  = 2'b01,
    OPC_BR = 2'b10,
    OPC_I  = 2'b11
  } opc_class_e;

  // Reserved low nibbles within the I and R opcode classes
  localparam logic [3:0] I_NIB_RSV0 = 4'h0;
  localparam logic [3:0] I_NIB_RSV1 = 4'h1;
  localparam logic [3:0] I_NIB_RSV8 = 4'h8;
  localparam logic [3:0] I_NIB_RSVD = 4'hD;
  localparam logic [3:0] I_NIB_RSVE = 4'hE;
  localparam logic [3:0] I_NIB_RSVF = 4'hF;
  localparam logic [3:0] R_NIB_RSVF = 4'hF;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 21;
  localparam int RS_HI   = 20;
  localparam int RS_LO   = 16;
  localparam int RT_HI   = 15;
  localparam int RT_LO   = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int BNE_BIT = 26;
  localparam int JUMP_W  = 26;

  function automatic logic is_illegal_opcode(input logic [5:0] opc);
    logic       bad;
    logic [3:0] nib;
    bad = 1'b0;
    nib = opc[3:0];
    unique case (opc_class_e'(opc[5:4]))
      OPC_I:   bad = nib inside {I_NIB_RSV0, I_NIB_RSV1, I_NIB_RSV8,
                                 I_NIB_RSVD, I_NIB_RSVE, I_NIB_RSVF};
      OPC_R:   bad = (nib == R_NIB_RSVF);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational IR field slicer plus the illegal-opcode detector for the word
// about to be loaded into IR.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] ir,
  input  logic [5:0]    load_opcode,
  output logic [5:0]    opcode,
  output logic [4:0]    rd,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [15:0]   imm,
  output logic          is_bne,
  output logic          load_illegal
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

  // The opcode LSB distinguishes BNE from BEQ for conditional PC loads
  assign is_bne = ir[BNE_BIT];

  assign load_illegal = is_illegal_opcode(load_opcode);

endmodule

// File: rtl/fetch_unit.sv
// PC/IR stage ahead of the multicycle controller: selects the next PC, drives the
// synchronous instruction memory, and tracks retired-instruction and illegal-op debug state.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              IW        = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic [PC_W-1:0]  alu_result,
  input  logic [PC_W-1:0]  alu_out,
  input  logic             zero,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [IW-1:0]    imem_rdata,
  output logic [PC_W-1:0]  pc,
  output logic [IW-1:0]    ir,
  output logic [5:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [15:0]      imm,
  output logic [CNT_W-1:0] ir_count,
  output logic             illegal_op
);

  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] jump_target;
  logic            is_bne;
  logic            load_illegal;
  logic            taken;
  logic            pc_en;

  fetch_decode #(.IW(IW)) u_decode (
    .ir           (ir),
    .load_opcode  (imem_rdata[OPC_HI:OPC_LO]),
    .opcode       (opcode),
    .rd           (rd),
    .rs           (rs),
    .rt           (rt),
    .imm          (imm),
    .is_bne       (is_bne),
    .load_illegal (load_illegal)
  );

  // Wide PCs keep their upper bits across a jump; narrow PCs take only IR bits
  if (PC_W <= JUMP_W) begin : g_jump_narrow
    assign jump_target = ir[PC_W-1:0];
  end else begin : g_jump_wide
    assign jump_target = {pc[PC_W-1:JUMP_W], ir[JUMP_W-1:0]};
  end

  always_comb begin
    pc_next = alu_result;
    unique case (pcsrc_e'(PCSource))
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = jump_target;
      PCSRC_RESET:  pc_next = RESET_VEC;
      default:      pc_next = alu_result;
    endcase
    taken = PCWriteCond & (is_bne ? ~zero : zero);
    pc_en = PCWrite | taken;
    // Presenting the next PC early lets the sync memory show mem[pc] one edge later
    if (reset)      imem_addr = RESET_VEC;
    else if (pc_en) imem_addr = pc_next;
    else            imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VEC;
      ir         <= '0;
      ir_count   <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (pc_en) pc <= pc_next;
      if (IRWrite) begin
        ir       <= imem_rdata;
        ir_count <= ir_count + CNT_W'(1);
        if (load_illegal) illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural fetch model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_fetch_unit;

  localparam int          PC_W = 16;
  localparam int          IW   = 32;
  localparam int          CNT_W = 32;
  localparam logic [15:0] RV   = 16'h0000;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IRWrite;
  logic [1:0]  PCSource;
  logic [15:0] alu_result;
  logic [15:0] alu_out;
  logic        zero;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] ir_count;
  logic        illegal_op;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_W(PC_W), .IW(IW), .RESET_VEC(RV), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .zero        (zero),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .ir_count    (ir_count),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of PC, IR, counter and the memory output
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_rdata;
  int unsigned m_cnt;
  bit          m_ill;
  bit          m_valid = 1'b0;
  logic [5:0]  illegal_list [7] = '{6'h30, 6'h31, 6'h38, 6'h3D, 6'h3E, 6'h3F, 6'h1F};

  function automatic bit in_illegal(input logic [5:0] o);
    foreach (illegal_list[k]) if (illegal_list[k] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_target();
    case (PCSource)
      2'd0:    return alu_result;
      2'd1:    return alu_out;
      2'd2:    return 16'(m_ir & 32'h03FF_FFFF);
      default: return RV;
    endcase
  endfunction

  function automatic bit model_load();
    if (PCWrite) return 1'b1;
    if (!PCWriteCond) return 1'b0;
    return m_ir[26] ? !zero : zero;
  endfunction

  function automatic logic [15:0] model_addr();
    if (reset) return RV;
    return model_load() ? model_target() : m_pc;
  endfunction

  always @(posedge clk) begin
    logic [15:0] a;
    logic [15:0] t;
    bit          lp;
    a  = model_addr();
    t  = model_target();
    lp = model_load();
    if (reset) begin
      m_pc  = RV;
      m_ir  = 32'h0;
      m_cnt = 0;
      m_ill = 1'b0;
    end else begin
      if (lp) m_pc = t;
      if (IRWrite) begin
        if (in_illegal(m_rdata[31:26])) m_ill = 1'b1;
        m_ir  = m_rdata;
        m_cnt = m_cnt + 1;
      end
    end
    m_rdata = mem[a];
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("pc", 32'(pc), 32'(m_pc));
      checkOutput("ir", ir, m_ir);
      checkOutput("ir_count", ir_count, m_cnt);
      checkOutput("illegal_op", 32'(illegal_op), 32'(m_ill));
      checkOutput("opcode", 32'(opcode), 32'(m_ir >> 26));
      checkOutput("rd", 32'(rd), (m_ir >> 21) & 32'h1F);
      checkOutput("rs", 32'(rs), (m_ir >> 16) & 32'h1F);
      checkOutput("rt", 32'(rt), (m_ir >> 11) & 32'h1F);
      checkOutput("imm", 32'(imm), m_ir & 32'hFFFF);
      checkOutput("imem_addr", 32'(imem_addr), 32'(model_addr()));
      checkOutput("imem_rdata", imem_rdata, m_rdata);
    end
  end

  task automatic applyStimulus(input bit rst, input bit pw, input bit pwc, input bit irw,
                               input logic [1:0] src, input logic [15:0] ar,
                               input logic [15:0] ao, input bit z);
    reset       = rst;
    PCWrite     = pw;
    PCWriteCond = pwc;
    IRWrite     = irw;
    PCSource    = src;
    alu_result  = ar;
    alu_out     = ao;
    zero        = z;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0800_0000 | 32'(i);
    mem[16'h0000] = 32'h4C00_0005;
    mem[16'h0001] = 32'h8000_0000;
    mem[16'h0040] = 32'h8400_0000;
    mem[16'h0041] = 32'h0400_0123;
    mem[16'h0123] = 32'hFC00_0000;

    applyStimulus(1, 0, 0, 0, 2'b00, 16'h0, 16'h0, 0);
    step();
    step();
    checkOutput("reset pc", 32'(pc), 32'h0);
    checkOutput("reset ir", ir, 32'h0);
    checkOutput("reset ir_count", ir_count, 32'h0);
    checkOutput("reset illegal_op", 32'(illegal_op), 32'h0);
    checkOutput("reset imem_addr", 32'(imem_addr), 32'h0);

    idle();
    applyStimulus(0, 1, 0, 1, 2'b00, 16'h0001, 16'h0, 0);
    step();
    checkOutput("IF ir", ir, 32'h4C00_0005);
    checkOutput("IF opcode", 32'(opcode), 32'h13);
    checkOutput("IF pc", 32'(pc), 32'h1);
    checkOutput("IF ir_count", ir_count, 32'h1);

    idle();
    applyStimulus(0, 0, 0, 1, 2'b00, 16'h0, 16'h0, 0);
    step();
    checkOutput("BEQ ir", ir, 32'h8000_0000);
    applyStimulus(0, 0, 1, 0, 2'b01, 16'h0, 16'h0040, 1);
    #1;
    checkOutput("BEQ imem_addr", 32'(imem_addr), 32'h40);
    step();
    checkOutput("BEQ pc", 32'(pc), 32'h40);

    idle();
    applyStimulus(0, 0, 0, 1, 2'b00, 16'h0, 16'h0, 0);
    step();
    applyStimulus(0, 0, 1, 0, 2'b01, 16'h0, 16'h0077, 1);
    #1;
    checkOutput("BNE nt imem_addr", 32'(imem_addr), 32'h40);
    step();
    checkOutput("BNE nt pc", 32'(pc), 32'h40);
    checkOutput("BNE nt ir", ir, 32'h8400_0000);

    applyStimulus(0, 1, 1, 0, 2'b00, 16'h0041, 16'h0, 1);
    step();
    checkOutput("forced load pc", 32'(pc), 32'h41);

    idle();
    applyStimulus(0, 0, 0, 1, 2'b00, 16'h0, 16'h0, 0);
    step();
    applyStimulus(0, 1, 0, 0, 2'b10, 16'h0, 16'h0, 0);
    step();
    checkOutput("jump pc", 32'(pc), 32'h123);
    idle();
    checkOutput("jump imem_rdata", imem_rdata, 32'hFC00_0000);

    applyStimulus(0, 1, 0, 1, 2'b00, 16'h0124, 16'h0, 0);
    step();
    checkOutput("illegal set", 32'(illegal_op), 32'h1);
    checkOutput("illegal ir", ir, 32'hFC00_0000);
    for (int i = 0; i < 3; i++) begin
      idle();
      applyStimulus(0, 1, 0, 1, 2'b00, 16'h0125 + 16'(i), 16'h0, 0);
      step();
      checkOutput("illegal sticky", 32'(illegal_op), 32'h1);
    end
    checkOutput("sticky ir_count", ir_count, 32'd8);

    applyStimulus(0, 1, 0, 0, 2'b11, 16'h0, 16'h0, 0);
    step();
    checkOutput("reset-vector pc", 32'(pc), 32'(RV));
    checkOutput("illegal after pcsrc 11", 32'(illegal_op), 32'h1);
    idle();
    applyStimulus(0, 1, 0, 1, 2'b00, 16'h0005, 16'h0, 0);
    step();
    checkOutput("refetch ir", ir, 32'h4C00_0005);

    applyStimulus(1, 1, 0, 1, 2'b01, 16'h0, 16'h00FF, 0);
    #1;
    checkOutput("mid reset imem_addr", 32'(imem_addr), 32'(RV));
    step();
    checkOutput("mid reset pc", 32'(pc), 32'(RV));
    checkOutput("mid reset ir", ir, 32'h0);
    checkOutput("mid reset ir_count", ir_count, 32'h0);
    checkOutput("mid reset illegal_op", 32'(illegal_op), 32'h0);

    idle();
    applyStimulus(0, 1, 0, 1, 2'b00, 16'h0001, 16'h0, 0);
    step();
    idle();
    applyStimulus(0, 0, 1, 0, 2'b01, 16'h0, 16'h0050, 1);
    step();
    checkOutput("BNE zero=1 pc", 32'(pc), 32'h1);
    applyStimulus(0, 0, 1, 0, 2'b01, 16'h0, 16'h0050, 0);
    step();
    checkOutput("BNE zero=0 pc", 32'(pc), 32'h50);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register stage that sits directly upstream of the multicycle controller: holds PC and IR, drives the synchronous instruction memory, and hands the opcode and decoded fields to the controller and datapath. It consumes the controller's PCWrite, PCWriteCond, IRWrite and PCSource outputs, plus the ALU result and zero flag. It also keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

## Interface
- PC_W, 16: PC and instruction-memory address width, word addressed.
- IW, 32: instruction width.
- RESET_VEC, 0: PC value loaded when PCSource = 2'b11.
- CNT_W, 32: retired-instruction counter width.

- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- PCWrite  in  1  unconditional PC load.
- PCWriteCond  in  1  conditional PC load, taken per branch rule.
- IRWrite  in  1  latch imem_rdata into IR.
- PCSource  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 RESET_VEC.
- alu_result  in  PC_W  combinational ALU output, which carries PC+1 in IF.
- alu_out  in  PC_W  registered ALU output, which carries the branch target computed in ID.
- zero  in  1  ALU zero flag.
- imem_addr  out  PC_W  synchronous-read instruction memory address.
- imem_rdata  in  IW  instruction memory data, valid one cycle after the address is sampled.
- pc  out  PC_W  current PC.
- ir  out  IW  instruction register.
- opcode  out  6  ir[31:26], to the controller.
- rd, rs, rt  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- imm  out  16  ir[15:0].
- ir_count  out  CNT_W  number of IR loads since reset.
- illegal_op  out  1  sticky flag for an illegal opcode.

## Operation
- pc_next mux:
  - 00: alu_result.
  - 01: alu_out.
  - 10: {pc[PC_W-1:PC_W-?] zero-padded, ir[25:0]}, truncated to PC_W. With PC_W ≤ 26 this is ir[PC_W-1:0].
  - 11: RESET_VEC.
- Branch rule: taken = PCWriteCond & (ir[26] ? ~zero : zero).
  - ir[26] = 0 means BEQ; ir[26] = 1 means BNE.
- PC load enable: pc_en = PCWrite | taken.
- PC update: when pc_en = 1, PC ← pc_next; otherwise PC holds.
- imem_addr = pc_en ? pc_next : pc, combinational.
  - The sync memory therefore always presents mem[pc] in the cycle after PC changes.
  - Consequence: imem_rdata == mem[pc] whenever pc has been stable for one edge.
- IRWrite = 1: IR ← imem_rdata and ir_count ← ir_count + 1.
  - ir_count wraps modulo 2^CNT_W.
- IRWrite and pc_en together: IR latches the instruction at the old PC, and PC advances in the same edge. This is the normal IF cycle.
- Field outputs are combinational slices of IR.
- illegal_op is set on any IR load whose opcode is one of:
  - 2'b11 with low nibble in {0000, 0001, 1000, 1101, 1110, 1111};
  - 2'b01 with low nibble 1111.
- illegal_op stays set until reset; it does not alter the IR load.

## Timing
- During reset: PC ← RESET_VEC, IR ← 0, ir_count ← 0, illegal_op ← 0, imem_addr = RESET_VEC.
  - After the release edge, imem_rdata = mem[RESET_VEC].
- Reset overrides every control input in the same cycle, including mid-instruction.
- Latency:
  - PC change is visible one cycle after pc_en.
  - IR is visible one cycle after IRWrite.
  - opcode is valid for the controller's ID state, which follows IF.
- Simultaneous PCWrite and PCWriteCond: the load happens regardless of the branch condition, and pc_next is still selected by PCSource.
- PCWriteCond with a branch not taken: PC, imem_addr and IR are all unchanged.
- IRWrite with PC not yet stable, e.g. in the cycle right after a PC load: IR captures whatever imem_rdata presents. The controller guarantees at least one idle cycle between a PC load and the next IRWrite.

## Structure
- Shared cpu_pkg holds:
  - PCSource encodings (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RESET);
  - opcode class constants (J, R, BR, I) and the I-type nibble constants;
  - IR field bit positions.
- One natural sub-module: fetch_decode, a pure combinational field slicer plus the illegal-opcode detector.

## Test plan
- Reset then IF:
  - Stimulus: hold reset 2 cycles; mem[0]=32'h4C000005; release; PCSource=00, alu_result=1, PCWrite=IRWrite=1 for one cycle.
  - Required: ir=32'h4C000005, opcode=6'h13, pc=1, ir_count=1.
- BEQ taken:
  - Stimulus: ir[31:26]=6'b100000, PCWriteCond=1, PCSource=01, alu_out=16'h0040, zero=1.
  - Required: pc=16'h0040, imem_addr=16'h0040 in that cycle.
- BNE not taken:
  - Stimulus: ir[26]=1, zero=1, PCWriteCond=1.
  - Required: pc unchanged, IR unchanged.
- Jump:
  - Stimulus: ir=32'h0400_0123, PCSource=10, PCWrite=1.
  - Required: pc=16'h0123, and imem_rdata=mem[16'h0123] on the next cycle.
- Illegal op:
  - Stimulus: load IR with opcode 6'b111111.
  - Required: illegal_op=1, which persists through 3 legal fetches and clears only on reset.
- Reset mid-instruction:
  - Stimulus: assert reset while PCWrite=1, PCSource=01, alu_out=16'h00FF.
  - Required: pc=RESET_VEC, ir=0, ir_count=0.
